// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU: combinational instruction ROM port and a req/ready data-memory
// bus that may insert wait states. A self-jump parks the core in a sticky halt.
module hack_cpu_mc #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 15,
    parameter int unsigned PC_W   = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  instr,
    input  logic [WIDTH-1:0]  mem_rdata,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    output logic [PC_W-1:0]   pc,
    output logic [WIDTH-1:0]  a_reg,
    output logic [WIDTH-1:0]  d_reg,
    output logic              halted
);

    typedef enum logic [1:0] {EXEC, RD, WR, HALT} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q;
    logic [WIDTH-1:0]  a_q, d_q, wdata_q;
    logic              halted_q;

    logic              is_c, a_bit, dest_a, dest_d, dest_m;
    logic [5:0]        comp;
    logic [2:0]        jump;
    logic [WIDTH-1:0]  y_sel, alu_out, res;
    logic              zr, ng, take, halt_hit;
    logic [PC_W-1:0]   pc_next;
    logic              commit, latch_w;

    // Standard Hack ALU: zx,nx,zy,ny,f,no
    function automatic logic [WIDTH-1:0] hack_alu(input logic [WIDTH-1:0] x_in,
                                                  input logic [WIDTH-1:0] y_in,
                                                  input logic [5:0]       c);
        logic [WIDTH-1:0] x, y, o;
        x = c[5] ? '0 : x_in;
        x = c[4] ? ~x : x;
        y = c[3] ? '0 : y_in;
        y = c[2] ? ~y : y;
        o = c[1] ? (x + y) : (x & y);
        return c[0] ? ~o : o;
    endfunction

    assign is_c   = instr[WIDTH-1];
    assign a_bit  = instr[12];
    assign comp   = instr[11:6];
    assign dest_a = instr[5];
    assign dest_d = instr[4];
    assign dest_m = instr[3];
    assign jump   = instr[2:0];

    // In RD the y operand is the word coming back from memory; in WR the result was latched
    assign y_sel   = (state_q == RD) ? mem_rdata : a_q;
    assign alu_out = hack_alu(d_q, y_sel, comp);
    assign res     = (state_q == WR) ? wdata_q : alu_out;

    assign zr       = (res == '0);
    assign ng       = res[WIDTH-1];
    assign take     = is_c & ((jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr));
    assign pc_next  = take ? a_q[PC_W-1:0] : pc_q + PC_W'(1);
    assign halt_hit = take & (a_q[PC_W-1:0] == pc_q);

    always_ff @(posedge clk) begin
        if (reset) state_q <= EXEC;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        latch_w = 1'b0;
        case (state_q)
            EXEC: begin
                if (!is_c) begin
                    commit = 1'b1;
                end else if (a_bit) begin
                    state_d = RD;
                end else if (dest_m) begin
                    latch_w = 1'b1;
                    state_d = WR;
                end else begin
                    commit = 1'b1;
                end
            end
            RD: begin
                if (mem_ready) begin
                    if (dest_m) begin
                        latch_w = 1'b1;
                        state_d = WR;
                    end else begin
                        commit = 1'b1;
                    end
                end
            end
            WR: begin
                if (mem_ready) commit = 1'b1;
            end
            HALT: state_d = HALT;
            default: state_d = EXEC;
        endcase
        if (commit) state_d = halt_hit ? HALT : EXEC;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            a_q      <= '0;
            d_q      <= '0;
            wdata_q  <= '0;
            halted_q <= 1'b0;
        end else begin
            if (latch_w) wdata_q <= alu_out;
            if (commit) begin
                if (!is_c) begin
                    a_q <= instr;
                end else begin
                    if (dest_a) a_q <= res;
                    if (dest_d) d_q <= res;
                end
                pc_q <= pc_next;
                if (halt_hit) halted_q <= 1'b1;
            end
        end
    end

    assign mem_req   = (state_q == RD) || (state_q == WR);
    assign mem_we    = (state_q == WR);
    assign mem_addr  = a_q[ADDR_W-1:0];
    assign mem_wdata = wdata_q;
    assign pc        = pc_q;
    assign a_reg     = a_q;
    assign d_reg     = d_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: ROM/RAM models with programmable wait states, a write
// scoreboard, and a second core with a 4-bit pc to exercise pc wrap.
module tb_hack_cpu_mc;

    localparam logic [5:0] C_ZERO = 6'b101010, C_ONE = 6'b111111, C_NEG1 = 6'b111010,
                           C_D = 6'b001100, C_A = 6'b110000, C_DP1 = 6'b011111,
                           C_AP1 = 6'b110111, C_DPA = 6'b000010;
    localparam logic [2:0] DST_D = 3'b010, DST_M = 3'b001, NOJ = 3'b000,
                           JLT = 3'b100, JEQ = 3'b010, JMP = 3'b111;

    typedef struct packed {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] instr, mem_rdata;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_we;
    logic [14:0] mem_addr, pc;
    logic [15:0] mem_wdata, a_reg, d_reg;
    logic        halted;

    logic [15:0] instr4, rdata4;
    logic        ready4;
    logic        req4, we4, halted4;
    logic [14:0] addr4;
    logic [15:0] wdata4, a4, d4;
    logic [3:0]  pc4;

    logic [15:0] rom  [0:63];
    logic [15:0] rom4 [0:15];
    logic [15:0] ram  [0:15];
    wr_t         sb[$];
    int          wait_states = 0;
    int          wcnt = 0;
    int          rd_cycles = 0, wr_cycles = 0, req_cycles = 0;
    int          checks = 0, failures = 0;

    hack_cpu_mc u_dut (
        .clk(clk), .reset(reset), .instr(instr), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .pc(pc), .a_reg(a_reg), .d_reg(d_reg), .halted(halted)
    );

    hack_cpu_mc #(.WIDTH(16), .ADDR_W(15), .PC_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .instr(instr4), .mem_rdata(rdata4),
        .mem_ready(ready4), .mem_req(req4), .mem_we(we4), .mem_addr(addr4),
        .mem_wdata(wdata4), .pc(pc4), .a_reg(a4), .d_reg(d4), .halted(halted4)
    );

    always #5 clk = ~clk;

    assign instr  = rom[pc[5:0]];
    assign instr4 = rom4[pc4];
    assign rdata4 = 16'h0000;
    assign ready4 = 1'b1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ci(input logic a, input logic [5:0] c,
                                       input logic [2:0] dst, input logic [2:0] j);
        return {3'b111, a, c, dst, j};
    endfunction

    function automatic logic [15:0] ai(input int unsigned v);
        return {1'b0, 15'(v)};
    endfunction

    // RAM responder: ready rises after wait_states cycles of an outstanding request
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ready = (wcnt >= wait_states);
            mem_rdata = ram[mem_addr[3:0]];
        end else begin
            mem_ready = 1'b0;
            mem_rdata = 16'hDEAD;
        end
    end

    // Bus monitor: cycle counters and scoreboard compare on every completed write
    always @(posedge clk) begin
        if (mem_req) req_cycles <= req_cycles + 1;
        if (mem_req && !mem_we) rd_cycles <= rd_cycles + 1;
        if (mem_req && mem_we)  wr_cycles <= wr_cycles + 1;
        if (mem_req && mem_ready && !reset) begin
            wcnt <= 0;
            if (mem_we) begin
                if (sb.size() == 0) begin
                    check_val("sb_unexpected_write", {17'd0, mem_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    check_val("sb_wr_addr", {17'd0, mem_addr}, {17'd0, e.addr});
                    check_val("sb_wr_data", {16'd0, mem_wdata}, {16'd0, e.data});
                end
            end
        end else if (mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    task automatic clear_rom();
        for (int i = 0; i < 64; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int r0, w0, q0;
        for (int i = 0; i < 16; i++) begin
            ram[i]  = 16'h0000;
            rom4[i] = 16'h0000;
        end

        // Test 1: @5; D=A; @7; D=D+A; @0; M=D with zero wait states
        clear_rom();
        rom[0] = ai(5); rom[1] = ci(1'b0, C_A, DST_D, NOJ);
        rom[2] = ai(7); rom[3] = ci(1'b0, C_DPA, DST_D, NOJ);
        rom[4] = ai(0); rom[5] = ci(1'b0, C_D, DST_M, NOJ);
        rom[6] = ai(7); rom[7] = ci(1'b0, C_ZERO, 3'b000, JMP);
        wait_states = 0;
        sb.push_back('{addr: 15'd0, data: 16'd12});
        do_reset();
        check_val("rst_pc", {17'd0, pc}, 32'd0);
        check_val("rst_a", {16'd0, a_reg}, 32'd0);
        check_val("rst_d", {16'd0, d_reg}, 32'd0);
        check_val("rst_halt", {31'd0, halted}, 32'd0);
        check_val("rst_req", {31'd0, mem_req}, 32'd0);
        step(4);
        check_val("t1_d12", {16'd0, d_reg}, 32'd12);
        step(1);
        check_val("t1_pc5", {17'd0, pc}, 32'd5);
        check_val("t1_noreq", {31'd0, mem_req}, 32'd0);
        step(1);
        check_val("t1_req", {31'd0, mem_req}, 32'd1);
        check_val("t1_we", {31'd0, mem_we}, 32'd1);
        check_val("t1_addr", {17'd0, mem_addr}, 32'd0);
        check_val("t1_wdata", {16'd0, mem_wdata}, 32'd12);
        step(1);
        check_val("t1_req_drop", {31'd0, mem_req}, 32'd0);
        check_val("t1_pc6", {17'd0, pc}, 32'd6);
        check_val("t1_sb_empty", sb.size(), 32'd0);

        // Test 2: read-modify-write M=M+1 with two wait states per transaction
        clear_rom();
        rom[0] = ai(3); rom[1] = ci(1'b1, C_AP1, DST_M, NOJ);
        rom[2] = ai(3); rom[3] = ci(1'b0, C_ZERO, 3'b000, JMP);
        ram[3] = 16'd41;
        wait_states = 2;
        sb.push_back('{addr: 15'd3, data: 16'd42});
        do_reset();
        step(2);
        r0 = rd_cycles; w0 = wr_cycles;
        check_val("t2_rd_req", {31'd0, mem_req}, 32'd1);
        check_val("t2_rd_we", {31'd0, mem_we}, 32'd0);
        check_val("t2_rd_addr", {17'd0, mem_addr}, 32'd3);
        step(5);
        check_val("t2_pc_hold", {17'd0, pc}, 32'd1);
        step(1);
        check_val("t2_pc2", {17'd0, pc}, 32'd2);
        check_val("t2_rd_cycles", rd_cycles - r0, 32'd3);
        check_val("t2_wr_cycles", wr_cycles - w0, 32'd3);
        check_val("t2_d_same", {16'd0, d_reg}, 32'd0);
        check_val("t2_sb_empty", sb.size(), 32'd0);

        // Test 3: conditional jumps on D
        clear_rom();
        rom[0]  = ci(1'b0, C_NEG1, DST_D, NOJ); rom[1]  = ai(10); rom[2]  = ci(1'b0, C_D, 3'b000, JLT);
        rom[10] = ci(1'b0, C_ONE, DST_D, NOJ);  rom[11] = ai(20); rom[12] = ci(1'b0, C_D, 3'b000, JLT);
        rom[13] = ci(1'b0, C_ZERO, DST_D, NOJ); rom[14] = ai(30); rom[15] = ci(1'b0, C_D, 3'b000, JEQ);
        rom[30] = ai(31); rom[31] = ci(1'b0, C_ZERO, 3'b000, JMP);
        wait_states = 0;
        do_reset();
        step(3);
        check_val("t3_jlt_taken", {17'd0, pc}, 32'd10);
        check_val("t3_dneg", {16'd0, d_reg}, 32'hFFFF);
        step(3);
        check_val("t3_jlt_not", {17'd0, pc}, 32'd13);
        check_val("t3_d1", {16'd0, d_reg}, 32'd1);
        step(3);
        check_val("t3_jeq_taken", {17'd0, pc}, 32'd30);

        // Test 4: self-jump at pc 4 halts
        clear_rom();
        rom[0] = ci(1'b0, C_ONE, DST_D, NOJ); rom[1] = ci(1'b0, C_DP1, DST_D, NOJ);
        rom[2] = ci(1'b0, C_DP1, DST_D, NOJ); rom[3] = ai(4);
        rom[4] = ci(1'b0, C_ZERO, 3'b000, JMP);
        do_reset();
        step(4);
        check_val("t4_not_yet", {31'd0, halted}, 32'd0);
        step(1);
        check_val("t4_halted", {31'd0, halted}, 32'd1);
        check_val("t4_pc", {17'd0, pc}, 32'd4);
        check_val("t4_d", {16'd0, d_reg}, 32'd3);
        q0 = req_cycles;
        step(20);
        check_val("t4_no_req", req_cycles - q0, 32'd0);
        check_val("t4_pc_frozen", {17'd0, pc}, 32'd4);
        check_val("t4_still_halted", {31'd0, halted}, 32'd1);

        // Test 5: reset while a read is stalled
        clear_rom();
        rom[0] = ai(3); rom[1] = ci(1'b1, C_A, DST_D, NOJ);
        rom[2] = ai(3); rom[3] = ci(1'b0, C_ZERO, 3'b000, JMP);
        ram[3] = 16'd77;
        wait_states = 1000;
        do_reset();
        step(5);
        check_val("t5_stalled", {31'd0, mem_req}, 32'd1);
        reset = 1'b1;
        step(1);
        check_val("t5_req0", {31'd0, mem_req}, 32'd0);
        check_val("t5_pc0", {17'd0, pc}, 32'd0);
        check_val("t5_a0", {16'd0, a_reg}, 32'd0);
        check_val("t5_d0", {16'd0, d_reg}, 32'd0);
        wait_states = 0;
        reset = 1'b0;
        step(3);
        check_val("t5_restart_d", {16'd0, d_reg}, 32'd77);
        check_val("t5_restart_pc", {17'd0, pc}, 32'd2);

        // Test 6: 4-bit pc wrap and 16-bit overflow into the sign bit
        rom4[0]  = ai(32767); rom4[1] = ci(1'b0, C_A, DST_D, NOJ);
        rom4[2]  = ci(1'b0, C_DP1, DST_D, NOJ); rom4[3] = ai(15);
        rom4[4]  = ci(1'b0, C_D, 3'b000, JLT);
        rom4[15] = ai(1);
        do_reset();
        step(3);
        check_val("t6_d8000", {16'd0, d4}, 32'h8000);
        step(2);
        check_val("t6_jlt_pc15", {28'd0, pc4}, 32'd15);
        step(1);
        check_val("t6_wrap_pc0", {28'd0, pc4}, 32'd0);
        check_val("t6_a1", {16'd0, a4}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hack_cpu_mc.md
Name: hack_cpu_mc

Overview:
Parametrised, multi-cycle successor to the single-cycle Hack computer. It executes the Hack instruction set over a combinational instruction-ROM port. Data memory sits behind an external req/ready handshake, so RAM may insert wait states. Read-modify-write (M on both sides) becomes two bus transactions. A self-jump stops the core with a sticky halt flag.

Parameters:
WIDTH, 16, data/register/instruction width; must be >=16. Instruction fields sit in bits [15:0]; bit WIDTH-1 is the A/C type bit.
ADDR_W, 15, data-memory address width; mem_addr = A[ADDR_W-1:0].
PC_W, 15, program-counter width; pc wraps modulo 2^PC_W.

Ports:
clk  in  1  single system clock; all state changes on rising edge
reset  in  1  synchronous, active-high; resets pc/A/D/FSM/halt
instr  in  WIDTH  ROM[pc], combinational, valid the same cycle
mem_rdata  in  WIDTH  RAM read data; valid when mem_ready=1 on a read
mem_ready  in  1  completes the current transaction on the edge where req&ready
mem_req  out  1  transaction request; registered-state decode
mem_we  out  1  1=write, 0=read; valid while mem_req=1
mem_addr  out  ADDR_W  A[ADDR_W-1:0]
mem_wdata  out  WIDTH  latched ALU result; valid while mem_we=1
pc  out  PC_W  program counter; also the ROM address
a_reg  out  WIDTH  A register
d_reg  out  WIDTH  D register
halted  out  1  sticky halt flag

Behaviour:
- Reset (sync, highest priority): pc=0, A=0, D=0, state=EXEC, halted=0. mem_req=0 from the cycle after the reset edge. Any in-flight transaction is abandoned.
- Decode: A-instr when instr[WIDTH-1]=0, then A<=instr.
- C-instr fields: a=instr[12]; comp zx,nx,zy,ny,f,no=instr[11:6]; dest A,D,M=instr[5:3]; jump lt,eq,gt=instr[2:0].
- ALU: standard Hack ALU at WIDTH bits. x=D; y=A when a=0, y=M when a=1. zr = (out==0); ng = out[WIDTH-1]. Addition wraps modulo 2^WIDTH.
- Jump taken = (lt&ng) | (eq&zr) | (gt&~ng&~zr).
- Commit: write dest regs. pc <= A_old[PC_W-1:0] if the jump is taken, else pc+1 (wrapping). A_old is the A value before this instruction.
- FSM states: EXEC, RD, WR, HALT.
  - EXEC, A-instr or C-instr without M: commit on this edge (1 cycle).
  - EXEC, C-instr with a=1: go to RD. No commit.
  - EXEC, C-instr with a=0 and dest M: latch ALU result into wdata, go to WR.
  - RD: mem_req=1, mem_we=0. Hold until mem_ready. On the ready edge compute the ALU with M=mem_rdata.
    - dest M set: latch result, go to WR.
    - otherwise: commit, go to EXEC.
  - WR: mem_req=1, mem_we=1. Hold until mem_ready. On the ready edge commit, go to EXEC.
  - mem_addr stays A_old throughout, since A updates only at commit.
  - HALT: no requests; pc/A/D frozen; exit only via reset.
- Latency with zero wait states: non-M 1 cycle; read-only 2; write-only 2; RMW 3. Each cycle with mem_ready=0 adds one.
- mem_ready is ignored when mem_req=0.
- Halt: at commit, if the jump is taken and A_old[PC_W-1:0]==pc, the instruction commits fully, then state=HALT and halted=1.
- instr must be stable while pc is unchanged; the core never changes pc mid-instruction.

Test Plan:
1. ready tied 1; program @5; D=A; @7; D=D+A; @0; M=D -> D=12 after cycle 4; cycle 6: mem_req=1, mem_we=1, addr 0, wdata 12 for one cycle; pc=6.
2. RAM[3]=41, program @3; M=M+1; ready asserted 2 cycles after each req rises -> read held 3 cycles, write held 3 cycles, wdata=42; pc=2 after 7 cycles; D unchanged.
3. D=-1 (D=-1 comp), @10; D;JLT -> pc=10. Then D=1, @20; D;JLT -> pc not taken, pc+1. D=0; D;JEQ -> taken.
4. At pc 4: @4, 0;JMP -> halted=1 after that commit; pc stays 4; mem_req stays 0 for 20 further cycles.
5. reset asserted during RD wait (ready=0) -> next cycle mem_req=0, pc=0, A=0, D=0; execution restarts from ROM[0].
6. PC_W=4, ROM[15]=@1 -> pc wraps 15->0. Also WIDTH=16: @32767; D=A; D=D+1 -> D=16'h8000, ng=1 (JLT taken).
